// File: rtl/shift_rows_pipe_pkg.sv
// Shared Rijndael ShiftRows constants, buffer state encoding and index helpers.
package aes_pkg;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // The 256-bit block shifts rows 2 and 3 one column further than the narrower widths.
  function automatic int row_offset(input int nb, input int r);
    if (nb == NB_256 && r >= 2) begin
      return r + 1;
    end else begin
      return r;
    end
  endfunction

  function automatic int idx(input int r, input int c);
    return r + 4 * c;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; pure wiring plus a 2:1 mux per byte.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4,
  parameter int DW = 32 * NB
) (
  input  logic [DW-1:0] data_i,
  input  logic          inv_i,
  output logic [DW-1:0] data_o
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF   = row_offset(NB, r);
      localparam int FWD_C = (c + OFF) % NB;
      localparam int INV_C = (c + NB - OFF) % NB;
      localparam int DST   = DW - 1 - 8 * idx(r, c);
      localparam int SRC_F = DW - 1 - 8 * idx(r, FWD_C);
      localparam int SRC_I = DW - 1 - 8 * idx(r, INV_C);

      assign data_o[DST -: 8] = inv_i ? data_i[SRC_I -: 8] : data_i[SRC_F -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage with a 2-entry skid buffer (valid/ready).
// Optional output-transfer counter enabled by SHIFT_ROWS_PERF_CNT_EN.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic                out_inv,
`ifdef SHIFT_ROWS_PERF_CNT_EN
  output logic [31:0]         xfer_cnt,
`endif
  output logic                busy
);

  localparam int DW = 32 * NB;

  if (!(NB == NB_128 || NB == NB_192 || NB == NB_256)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  buf_state_e    state;
  logic [DW-1:0] perm_data;
  logic [DW-1:0] main_data;
  logic          main_inv;
  logic [DW-1:0] skid_data;
  logic          skid_inv;
  logic          ready_q;
  logic          valid_q;
  logic          in_xfer;
  logic          out_xfer;

  shift_rows_perm #(
    .NB (NB),
    .DW (DW)
  ) u_perm (
    .data_i (in_data),
    .inv_i  (in_inv),
    .data_o (perm_data)
  );

  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = valid_q & out_ready;

  // Buffer FSM; ready/valid are registered with the state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BUF_EMPTY;
      main_data <= '0;
      main_inv  <= 1'b0;
      skid_data <= '0;
      skid_inv  <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        BUF_EMPTY: begin
          if (in_xfer) begin
            main_data <= perm_data;
            main_inv  <= in_inv;
            valid_q   <= 1'b1;
            state     <= BUF_ONE;
          end else begin
            valid_q   <= 1'b0;
          end
        end
        BUF_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_data <= perm_data;
            skid_inv  <= in_inv;
            ready_q   <= 1'b0;
            state     <= BUF_TWO;
          end else if (in_xfer && out_xfer) begin
            main_data <= perm_data;
            main_inv  <= in_inv;
          end else if (out_xfer) begin
            valid_q   <= 1'b0;
            state     <= BUF_EMPTY;
          end else begin
            valid_q   <= 1'b1;
          end
        end
        BUF_TWO: begin
          if (out_xfer) begin
            main_data <= skid_data;
            main_inv  <= skid_inv;
            state     <= BUF_ONE;
          end else begin
            ready_q   <= 1'b0;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= BUF_EMPTY;
        end
      endcase
    end
  end

`ifdef SHIFT_ROWS_PERF_CNT_EN
  logic [31:0] cnt;

  // Free-running count of output transfers; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 32'd0;
    end else if (out_xfer) begin
      cnt <= cnt + 32'd1;
    end else begin
      cnt <= cnt;
    end
  end

  assign xfer_cnt = cnt;
`endif

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign busy      = valid_q;
  assign out_data  = main_data;
  assign out_inv   = main_inv;

endmodule
